spi_master: RTL and testbench

- SPI master for the 16-bit register-access frame used by our CPLD SPI slave.
- Byte 1 is {rw, addr[6:0]}; byte 2 is the write data (rw=0) or the read data returned on miso (rw=1).
- Sits on the host/MCU side and turns a one-cycle start request into a complete nss/sck/mosi frame.
- Returns the captured read byte with a done pulse.
- SPI mode: CPOL=0, CPHA=0, MSB first, nss active low.

---
 rtl/spi_master.sv | 147 ++++++++++++++
 tb/tb_spi_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI master (CPOL=0, CPHA=0, MSB first) for the 16-bit {rw, addr[6:0], data[7:0]} register-access frame.
//
// Ports:
//   i_clk      system clock, all logic on the rising edge
//   i_reset_n  asynchronous active-low reset
//   i_start    transaction request, sampled only while idle
//   i_rw       1 = read, 0 = write (captured on accept)
//   i_addr     7-bit register address (captured on accept)
//   i_wdata    8-bit write data, shifted out for reads too (captured on accept)
//   i_miso     serial data from the slave
//   o_busy     high from the accept edge until the end of the inter-frame gap
//   o_done     one-cycle pulse at frame end
//   o_rdata    last read byte, valid with o_done on a read
//   o_nss      slave select, active low
//   o_sck      serial clock, idle low
//   o_mosi     serial data to the slave
//
// Frame timing in units of CLK_DIV (legal 2..255) clk cycles:
//   SETUP 1, SHIFT 32 half-periods, HOLD 1, GAP 1
//   -> nss low for 34*CLK_DIV cycles, busy high for 35*CLK_DIV cycles.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic       i_miso,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_nss,
    output logic       o_sck,
    output logic       o_mosi
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_t      r_state;
    logic [7:0]  r_div;
    logic [4:0]  r_edges;
    logic [15:0] r_tx;
    logic [7:0]  r_rx;
    logic        r_rw;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_rdata;
    logic        r_nss;
    logic        r_sck;
    logic        r_mosi;

    // Half-period boundary: the divider has run down to zero.
    logic w_tick;
    assign w_tick = (r_div == 8'd0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_div   <= 8'd0;
            r_edges <= 5'd0;
            r_tx    <= 16'd0;
            r_rx    <= 8'd0;
            r_rw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
            r_nss   <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE)
                r_div <= w_tick ? DIV_M1 : r_div - 8'd1;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_SETUP;
                        r_div   <= DIV_M1;
                        r_edges <= 5'd0;
                        r_tx    <= {i_rw, i_addr, i_wdata};
                        r_rw    <= i_rw;
                        r_busy  <= 1'b1;
                        r_nss   <= 1'b0;
                        r_sck   <= 1'b0;
                        r_mosi  <= i_rw;
                    end
                end
                // sck stays low for one half-period so mosi bit 15 is set up
                // well ahead of the first rising edge.
                S_SETUP: begin
                    if (w_tick)
                        r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_sck <= ~r_sck;
                        if (!r_sck) begin
                            // Rising edge: sample miso. Only the last eight
                            // samples (byte 2) survive in the 8-bit register.
                            r_rx    <= {r_rx[6:0], i_miso};
                            r_edges <= r_edges + 5'd1;
                        end else if (r_edges == 5'd16) begin
                            r_state <= S_HOLD;
                        end else begin
                            // Falling edge: present the next bit.
                            r_mosi <= r_tx[14];
                            r_tx   <= {r_tx[14:0], 1'b0};
                        end
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_state <= S_GAP;
                        r_nss   <= 1'b1;
                        r_done  <= 1'b1;
                        r_mosi  <= 1'b0;
                        if (r_rw)
                            r_rdata <= r_rx;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_rdata = r_rdata;
    assign o_nss   = r_nss;
    assign o_sck   = r_sck;
    assign o_mosi  = r_mosi;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized self-checking bench for spi_master at CLK_DIV=4 and CLK_DIV=2.
`timescale 1ns/1ps
module tb_spi_master;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic       start[2], rw[2], miso[2], busy[2], done[2], nss[2], sck[2], mosi[2];
    logic [6:0] addr[2];
    logic [7:0] wdata[2], rdata[2];

    spi_master #(.CLK_DIV(4)) u_dut0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start[0]), .i_rw(rw[0]),
        .i_addr(addr[0]), .i_wdata(wdata[0]), .i_miso(miso[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_rdata(rdata[0]),
        .o_nss(nss[0]), .o_sck(sck[0]), .o_mosi(mosi[0])
    );

    spi_master #(.CLK_DIV(2)) u_dut1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start[1]), .i_rw(rw[1]),
        .i_addr(addr[1]), .i_wdata(wdata[1]), .i_miso(miso[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_rdata(rdata[1]),
        .o_nss(nss[1]), .o_sck(sck[1]), .o_mosi(mosi[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state: what the frame must carry, what the slave returns,
    // and what rdata must hold.
    logic [15:0] exp_frame[2];
    logic [15:0] slave_word[2];
    logic [7:0]  exp_rdata[2];
    bit          mon_en[2];

    int done_cnt[2]   = '{0, 0};
    int frame_cnt[2]  = '{0, 0};
    int rise_cnt[2]   = '{0, 0};
    int frame_rise[2] = '{0, 0};
    int gap[2]        = '{0, 0};

    // Per-DUT slave model plus frame/timing monitor, sampled on the falling clk edge.
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int D = (g == 0) ? 4 : 2;
        logic p_nss = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_busy = 1'b0;
        int age = 0, lo_len = 0, hi_len = 0, busy_len = 0, idx = 0;
        logic [15:0] cap = 16'd0;
        always @(negedge clk) begin
            age = (mosi[g] !== p_mosi) ? 1 : age + 1;
            if (mon_en[g] && nss[g] !== p_nss) begin
                check("sck_at_nss", 32'(sck[g]), 32'd0);
                check("sck_before_nss", 32'(p_sck), 32'd0);
            end
            if (p_nss && !nss[g]) begin
                gap[g] = hi_len;
                lo_len = 1;
                frame_cnt[g]++;
                frame_rise[g] = 0;
                cap = 16'd0;
                idx = 0;
                miso[g] = slave_word[g][15];
            end else if (!p_nss && nss[g]) begin
                if (mon_en[g]) begin
                    check("nss_low_len", lo_len, 34 * D);
                    check("frame_rises", frame_rise[g], 16);
                    check("mosi_frame", 32'(cap), 32'(exp_frame[g]));
                end
                hi_len = 1;
            end else if (nss[g]) begin
                hi_len++;
            end else begin
                lo_len++;
            end
            if (!p_sck && sck[g]) begin
                rise_cnt[g]++;
                frame_rise[g]++;
                cap = {cap[14:0], mosi[g]};
                if (mon_en[g])
                    check("mosi_setup", 32'(age > D), 32'd1);
            end
            if (p_sck && !sck[g]) begin
                idx++;
                if (idx < 16)
                    miso[g] = slave_word[g][15 - idx];
            end
            if (busy[g] && !p_busy)
                busy_len = 1;
            else if (busy[g])
                busy_len++;
            if (!busy[g] && p_busy && mon_en[g])
                check("busy_len", busy_len, 35 * D);
            if (done[g]) begin
                done_cnt[g]++;
                if (mon_en[g])
                    check("rdata_at_done", 32'(rdata[g]), 32'(exp_rdata[g]));
            end
            p_nss  = nss[g];
            p_sck  = sck[g];
            p_mosi = mosi[g];
            p_busy = busy[g];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input int g, input logic r, input logic [6:0] a, input logic [7:0] w, input logic [7:0] sb);
        slave_word[g] = {8'($urandom), sb};
        exp_frame[g]  = {r, a, w};
        if (r)
            exp_rdata[g] = sb;
        @(negedge clk);
        start[g] = 1'b1;
        rw[g]    = r;
        addr[g]  = a;
        wdata[g] = w;
        @(negedge clk);
        start[g] = 1'b0;
        rw[g]    = 1'($urandom);
        addr[g]  = 7'($urandom);
        wdata[g] = 8'($urandom);
    endtask

    task automatic wait_done(input int g, input int target, input string tag);
        for (int i = 0; i < 400 && done_cnt[g] < target; i++)
            tick();
        check(tag, done_cnt[g], target);
        for (int i = 0; i < 20 && busy[g]; i++)
            tick();
        check({tag, "_idle"}, 32'(busy[g]), 32'd0);
        check({tag, "_rdata"}, 32'(rdata[g]), 32'(exp_rdata[g]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t, f, r;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; rw[g] = 1'b0; addr[g] = 7'd0; wdata[g] = 8'd0; miso[g] = 1'b0;
            mon_en[g] = 1'b1; exp_rdata[g] = 8'h00; slave_word[g] = 16'd0; exp_frame[g] = 16'd0;
        end
        #1 reset_n = 1'b0;
        #10;
        for (int g = 0; g < 2; g++) begin
            check("reset_nss", 32'(nss[g]), 32'd1);
            check("reset_sck", 32'(sck[g]), 32'd0);
            check("reset_mosi", 32'(mosi[g]), 32'd0);
            check("reset_busy", 32'(busy[g]), 32'd0);
            check("reset_done", 32'(done[g]), 32'd0);
            check("reset_rdata", 32'(rdata[g]), 32'd0);
        end
        #20;
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Directed write, then directed read returning 8'h3C.
        t = done_cnt[0] + 1;
        launch(0, 1'b0, 7'h15, 8'hA5, 8'($urandom));
        wait_done(0, t, "write_done");
        t = done_cnt[0] + 1;
        launch(0, 1'b1, 7'h02, 8'($urandom), 8'h3C);
        wait_done(0, t, "read_done");

        // Random traffic on both dividers.
        for (int i = 0; i < 6; i++) begin
            t = done_cnt[0] + 1;
            launch(0, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            wait_done(0, t, "rand0_done");
        end
        for (int i = 0; i < 4; i++) begin
            t = done_cnt[1] + 1;
            launch(1, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            wait_done(1, t, "rand1_done");
        end

        // A start pulse during SHIFT must be neither honoured nor queued.
        t = done_cnt[0] + 1;
        f = frame_cnt[0] + 1;
        launch(0, 1'b0, 7'h33, 8'h5A, 8'($urandom));
        for (int i = 0; i < 200 && frame_rise[0] != 3; i++)
            tick();
        check("busy_reach_shift", frame_rise[0], 3);
        start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 7'h6B; wdata[0] = 8'hE1;
        tick();
        start[0] = 1'b0;
        wait_done(0, t, "busy_start_done");
        repeat (200) tick();
        check("busy_start_frames", frame_cnt[0], f);
        check("busy_start_dones", done_cnt[0], t);

        // Asynchronous reset after the 5th rising sck edge of a read.
        t = done_cnt[0];
        launch(0, 1'b1, 7'h11, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 200 && frame_rise[0] != 5; i++)
            tick();
        check("mid_reach_rise5", frame_rise[0], 5);
        f = frame_cnt[0];
        mon_en[0] = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_nss", 32'(nss[0]), 32'd1);
        check("mid_rst_sck", 32'(sck[0]), 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_mosi", 32'(mosi[0]), 32'd0);
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        check("mid_rst_rdata", 32'(rdata[0]), 32'(exp_rdata[0]));
        repeat (3) begin
            tick();
            check("mid_rst_done", 32'(done[0]), 32'd0);
        end
        #2 reset_n = 1'b1;
        repeat (200) tick();
        check("mid_no_resume_done", done_cnt[0], t);
        check("mid_no_resume_frame", frame_cnt[0], f);
        check("mid_no_resume_nss", 32'(nss[0]), 32'd1);
        mon_en[0] = 1'b1;
        t = done_cnt[0] + 1;
        launch(0, 1'b1, 7'h44, 8'($urandom), 8'($urandom));
        wait_done(0, t, "post_rst_read");

        // Back-to-back on CLK_DIV=2 with start held high.
        t = done_cnt[1] + 2;
        f = frame_cnt[1] + 2;
        r = rise_cnt[1];
        slave_word[1] = {8'($urandom), 8'hC3};
        exp_frame[1]  = {1'b1, 7'h2A, 8'h77};
        exp_rdata[1]  = 8'hC3;
        @(negedge clk);
        start[1] = 1'b1; rw[1] = 1'b1; addr[1] = 7'h2A; wdata[1] = 8'h77;
        for (int i = 0; i < 300 && frame_cnt[1] < f; i++)
            tick();
        check("b2b_second_accept", frame_cnt[1], f);
        start[1] = 1'b0;
        wait_done(1, t, "b2b_done");
        repeat (20) tick();
        check("b2b_gap", gap[1], 3);
        check("b2b_rises", rise_cnt[1] - r, 32);
        check("b2b_frames", frame_cnt[1], f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
